// File: rtl/result_demux_pkg.sv
// result_demux_pkg
//   Shared definitions for the write-back result distributor:
//   destination-select encodings and the queue-entry layout
//   {sel, addr, data} stored by the 2-entry result FIFO.
package result_demux_pkg;

  localparam int RES_N = 16;  // result word / counter width
  localparam int RES_A = 3;   // destination address width

  localparam logic DEST_RF  = 1'b0;
  localparam logic DEST_MEM = 1'b1;

  typedef struct packed {
    logic             sel;
    logic [RES_A-1:0] addr;
    logic [RES_N-1:0] data;
  } result_entry_t;

endpackage

// File: rtl/result_fifo2.sv
// result_fifo2
//   Two-entry in-order FIFO holding queue entries of type T.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     push       write wr_entry at the tail (caller guarantees not full)
//     wr_entry   entry to write
//     pop        drop the head entry (caller guarantees not empty)
//     rd_entry   head entry; reads all zeros while empty
//     empty/full occupancy flags, registered
//     ready      registered "can accept next cycle"; low during reset and
//                for the cycle in which reset releases
module result_fifo2
  import result_demux_pkg::*;
#(
  parameter type T = result_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wr_entry,
  input  logic pop,
  output T     rd_entry,
  output logic empty,
  output logic full,
  output logic ready
);

  logic [1:0] occ;
  logic [1:0] occ_next;
  logic       rd_ptr;
  logic       wr_ptr;
  T           mem [2];

  always_comb begin
    occ_next = occ + {1'b0, push} - {1'b0, pop};
  end

  // Control state: pointers, occupancy and the registered ready flag.
  // ready is computed from next-state occupancy so it never depends on a
  // same-cycle pop seen combinationally by the upstream side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      ready  <= 1'b0;
    end else begin
      occ   <= occ_next;
      ready <= (occ_next != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign empty    = (occ == 2'd0);
  assign full     = (occ == 2'd2);
  assign rd_entry = empty ? T'('0) : mem[rd_ptr];

endmodule

// File: rtl/result_demux.sv
// result_demux
//   Write-back result distributor. Accepts one result word per handshake,
//   queues it (2 entries, strict FIFO order) and presents the head to
//   either the register-file port (sel=0) or the data-memory port (sel=1).
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     in_valid/in_ready            upstream handshake
//     in_data/in_sel/in_addr       result word, destination, address
//     rf_valid/rf_ready            register-file handshake
//     rf_data/rf_addr              head word and register index
//     mem_valid/mem_ready          data-memory handshake
//     mem_data/mem_addr            head word and memory address
//     rf_count/mem_count           wrapping per-destination delivery counts
//   All outputs derive only from registers.
module result_demux
  import result_demux_pkg::*;
#(
  parameter int N = RES_N,
  parameter int A = RES_A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_sel,
  input  logic [A-1:0] in_addr,
  output logic         rf_valid,
  input  logic         rf_ready,
  output logic [N-1:0] rf_data,
  output logic [A-1:0] rf_addr,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic [N-1:0] mem_data,
  output logic [A-1:0] mem_addr,
  output logic [N-1:0] rf_count,
  output logic [N-1:0] mem_count
);

  result_entry_t wr_entry;
  result_entry_t head;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          rf_fire;
  logic          mem_fire;

  assign wr_entry = '{sel: in_sel, addr: in_addr, data: in_data};
  assign push     = in_valid && in_ready && !full;

  result_fifo2 #(
    .T(result_entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (head),
    .empty    (empty),
    .full     (full),
    .ready    (in_ready)
  );

  // Head routing: exactly one destination sees the head; the other port's
  // ready is ignored, which gives head-of-line blocking.
  assign rf_valid  = !empty && (head.sel == DEST_RF);
  assign mem_valid = !empty && (head.sel == DEST_MEM);
  assign rf_data   = head.data;
  assign rf_addr   = head.addr;
  assign mem_data  = head.data;
  assign mem_addr  = head.addr;

  assign rf_fire  = rf_valid && rf_ready;
  assign mem_fire = mem_valid && mem_ready;
  assign pop      = rf_fire || mem_fire;

  // Delivery counters, updated on the handshake edge and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_count  <= '0;
      mem_count <= '0;
    end else begin
      if (rf_fire)  rf_count  <= rf_count + 1'b1;
      if (mem_fire) mem_count <= mem_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_result_demux.sv
module tb_result_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic [2:0]  in_addr = '0;
  logic        rf_valid;
  logic        rf_ready = 1'b0;
  logic [15:0] rf_data;
  logic [2:0]  rf_addr;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_data;
  logic [2:0]  mem_addr;
  logic [15:0] rf_count;
  logic [15:0] mem_count;

  always #5 clk = ~clk;

  result_demux dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_addr   (in_addr),
    .rf_valid  (rf_valid),
    .rf_ready  (rf_ready),
    .rf_data   (rf_data),
    .rf_addr   (rf_addr),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .mem_addr  (mem_addr),
    .rf_count  (rf_count),
    .mem_count (mem_count)
  );

  // Reference model: a queue of words in arrival order plus two counters.
  typedef struct {
    bit sel;
    int addr;
    int data;
  } word_t;

  word_t q[$];
  int    exp_rf_cnt  = 0;
  int    exp_mem_cnt = 0;
  bit    post_rst    = 1'b1;
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic bit m_ready();
    return !rst && !post_rst && (q.size() < 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit    has;
    word_t h;
    has = (q.size() > 0);
    if (has) h = q[0];
    else h = '{sel: 1'b0, addr: 0, data: 0};
    chk("in_ready",  32'(in_ready),  32'(m_ready()));
    chk("rf_valid",  32'(rf_valid),  32'(has && !h.sel));
    chk("mem_valid", 32'(mem_valid), 32'(has && h.sel));
    chk("rf_data",   32'(rf_data),   32'(h.data));
    chk("rf_addr",   32'(rf_addr),   32'(h.addr));
    chk("mem_data",  32'(mem_data),  32'(h.data));
    chk("mem_addr",  32'(mem_addr),  32'(h.addr));
    chk("rf_count",  32'(rf_count),  32'(exp_rf_cnt));
    chk("mem_count", 32'(mem_count), 32'(exp_mem_cnt));
  endtask

  // One clock: decide handshakes from the model before the edge, advance
  // the model at the edge, then compare #1 later.
  task automatic tick(input bit do_chk);
    bit    push;
    bit    pop;
    word_t w;
    push = in_valid && m_ready();
    pop  = (q.size() > 0) && (q[0].sel ? mem_ready : rf_ready);
    w    = '{sel: in_sel, addr: int'(in_addr), data: int'(in_data)};
    @(posedge clk);
    if (pop) begin
      if (q[0].sel) exp_mem_cnt = (exp_mem_cnt + 1) % 65536;
      else          exp_rf_cnt  = (exp_rf_cnt + 1) % 65536;
      void'(q.pop_front());
    end
    if (push) q.push_back(w);
    post_rst = 1'b0;
    #1;
    if (do_chk) check_all();
  endtask

  task automatic model_clear();
    q.delete();
    exp_rf_cnt  = 0;
    exp_mem_cnt = 0;
    post_rst    = 1'b1;
  endtask

  task automatic drive(input bit v, input bit s, input int a, input int d);
    in_valid = v;
    in_sel   = s;
    in_addr  = 3'(a);
    in_data  = 16'(d);
  endtask

  initial begin
    int base_rf;
    int base_mem;

    // Reset held across edges, then released mid-cycle.
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    #2 rst = 1'b0;
    #1 check_all();
    tick(1);
    chk("ready_after_release", 32'(in_ready), 32'd1);

    // Register-file write.
    rf_ready = 1'b1;
    drive(1'b1, 1'b0, 3, 16'h0014);
    tick(1);
    drive(1'b0, 1'b0, 0, 0);
    chk("rf_write_data", 32'(rf_data), 32'h0014);
    chk("rf_write_addr", 32'(rf_addr), 32'd3);
    tick(1);
    chk("rf_write_count", 32'(rf_count), 32'd1);
    chk("rf_write_mem_valid", 32'(mem_valid), 32'd0);
    chk("rf_write_drained", 32'(rf_valid), 32'd0);

    // Backpressure and head-of-line blocking.
    rf_ready  = 1'b0;
    mem_ready = 1'b0;
    drive(1'b1, 1'b1, 5, 16'h000A);
    tick(1);
    drive(1'b1, 1'b0, 2, 16'h0014);
    tick(1);
    drive(1'b0, 1'b0, 0, 0);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("bp_mem_hold", 32'(mem_data), 32'h000A);
    end
    rf_ready = 1'b1;
    for (int i = 0; i < 2; i++) tick(1);
    chk("bp_no_pop", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1;
    tick(1);
    chk("bp_mem_count", 32'(mem_count), 32'd1);
    chk("bp_rf_next", 32'(rf_data), 32'h0014);
    chk("bp_rf_valid", 32'(rf_valid), 32'd1);
    tick(1);

    // Streaming: 8 words, alternating destinations, both readies high.
    base_rf  = exp_rf_cnt;
    base_mem = exp_mem_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'(i % 2), i, 16'h0100 + i);
      tick(1);
    end
    drive(1'b0, 1'b0, 0, 0);
    tick(1);
    chk("stream_rf_count",  32'(rf_count),  32'(base_rf + 4));
    chk("stream_mem_count", 32'(mem_count), 32'(base_mem + 4));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
      rf_ready  = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      tick(1);
    end

    // Mid-run asynchronous reset with traffic queued.
    drive(1'b0, 1'b0, 0, 0);
    rf_ready  = 1'b0;
    mem_ready = 1'b0;
    rst = 1'b1;
    model_clear();
    #1 check_all();
    tick(1);
    #2 rst = 1'b0;
    tick(1);

    // Counter wrap: stream register-file words until the count reaches 0xFFFF.
    rf_ready = 1'b1;
    drive(1'b1, 1'b0, 1, 16'h5555);
    for (int i = 0; i < 70000 && exp_rf_cnt != 65535; i++) tick(0);
    drive(1'b0, 1'b0, 0, 0);
    check_all();
    chk("wrap_preload", 32'(rf_count), 32'hFFFF);
    for (int i = 0; i < 3; i++) tick(1);
    chk("wrap_zero", 32'(rf_count), 32'h0000);

    // Reset while a word is queued: it must vanish and never be delivered.
    rf_ready = 1'b0;
    drive(1'b1, 1'b0, 6, 16'hBEEF);
    tick(1);
    drive(1'b0, 1'b0, 0, 0);
    chk("queued_before_rst", 32'(rf_valid), 32'd1);
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_drops_valid", 32'(rf_valid), 32'd0);
    chk("rst_clears_data", 32'(rf_data), 32'd0);
    chk("rst_ready_low", 32'(in_ready), 32'd0);
    tick(1);
    #2 rst = 1'b0;
    rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(1);
    chk("discarded_rf_count", 32'(rf_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
